// File: rtl/ov9655_capture_pkg.sv
// Shared types for the OV9655 capture front end: FSM states and the
// stream entry stored in the output pixel FIFO.
package ov9655_capture_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FS,
    ACTIVE,
    DROP
  } cap_state_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [15:0] pix;
  } stream_entry_t;

  localparam int ENTRY_W = $bits(stream_entry_t);

endpackage

// File: rtl/ov9655_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags. Push is accepted
// when full if a pop happens in the same cycle.
module ov9655_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [AW:0] CNT_FULL = AW1'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    do_rd     = rd_en & ~empty;
    do_wr     = wr_en & (~full | do_rd);
    count_nxt = count + AW1'(do_wr) - AW1'(do_rd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Forced to zero while empty so the stream outputs read 0 out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ov9655_capture_stream.sv
// OV9655 parallel-bus capture: synchronizes the camera pins into ACLK,
// packs byte pairs into RGB565 and emits them as an AXI4-Stream video stream.
//
// state   | meaning
// IDLE    | capture disabled
// WAIT_FS | enabled, waiting for vsync falling edge
// ACTIVE  | capturing and pushing pixels
// DROP    | FIFO overflowed, discarding until frame end
module ov9655_capture_stream
  import ov9655_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FCNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              ctrl_enable,
  input  logic              ctrl_clear,
  output logic [15:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tuser,
  output logic              m_axis_tlast,
  output logic [FCNT_W-1:0] stat_frame_cnt,
  output logic              stat_overflow,
  output logic              stat_odd_line,
  output logic              stat_busy
);

  logic [SYNC_STAGES:0]        pclk_sr;
  logic [SYNC_STAGES:0]        vsync_sr;
  logic [SYNC_STAGES:0]        href_sr;
  logic [SYNC_STAGES-1:0][7:0] data_sr;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pclk_sr  <= '0;
      vsync_sr <= '0;
      href_sr  <= '0;
      data_sr  <= '0;
    end else begin
      pclk_sr  <= {pclk_sr[SYNC_STAGES-1:0], cam_pclk};
      vsync_sr <= {vsync_sr[SYNC_STAGES-1:0], cam_vsync};
      href_sr  <= {href_sr[SYNC_STAGES-1:0], cam_href};
      data_sr  <= {data_sr[SYNC_STAGES-2:0], cam_data};
    end
  end

  cap_state_t    state;
  logic          phase_odd;
  logic [7:0]    hi_byte;
  logic          hold_valid;
  logic [15:0]   hold_pix;
  logic          hold_sof;
  logic          sof_pending;
  logic [FCNT_W-1:0] frame_cnt;
  logic          overflow_q;
  logic          odd_q;

  logic          strobe;
  logic          href_s;
  logic [7:0]    data_s;
  logic          fs;
  logic          fe;
  logic          href_rise;
  logic          href_fall;
  logic          active;
  logic          phase_eff;
  logic          byte_in;
  logic          pix_done;
  logic          line_end;
  logic          push_req;
  logic          fifo_ok;
  logic          push;
  logic          overflow_evt;
  logic          odd_evt;
  stream_entry_t push_entry;
  stream_entry_t pop_entry;
  logic          fifo_full;
  logic          fifo_empty;

  always_comb begin
    strobe    = pclk_sr[SYNC_STAGES-1] & ~pclk_sr[SYNC_STAGES];
    href_s    = href_sr[SYNC_STAGES-1];
    data_s    = data_sr[SYNC_STAGES-1];
    fs        = ~vsync_sr[SYNC_STAGES-1] &  vsync_sr[SYNC_STAGES];
    fe        =  vsync_sr[SYNC_STAGES-1] & ~vsync_sr[SYNC_STAGES];
    href_rise =  href_s & ~href_sr[SYNC_STAGES];
    href_fall = ~href_s &  href_sr[SYNC_STAGES];
    active    = (state == ACTIVE);
    phase_eff = phase_odd & ~href_rise;
    byte_in   = active & strobe & href_s;
    pix_done  = byte_in & phase_eff;
    // Frame end also flushes a held pixel in case href never fell.
    line_end  = active & (href_fall | fe);
    push_req  = hold_valid & (pix_done | line_end);
    fifo_ok   = ~fifo_full | m_axis_tready;
    push      = push_req & fifo_ok;
    overflow_evt = push_req & ~fifo_ok;
    odd_evt   = line_end & phase_odd;
    push_entry.sof = hold_sof;
    push_entry.eol = line_end;
    push_entry.pix = hold_pix;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      phase_odd   <= 1'b0;
      hi_byte     <= '0;
      hold_valid  <= 1'b0;
      hold_pix    <= '0;
      hold_sof    <= 1'b0;
      sof_pending <= 1'b0;
      frame_cnt   <= '0;
      overflow_q  <= 1'b0;
      odd_q       <= 1'b0;
    end else begin
      overflow_q <= overflow_evt | (overflow_q & ~ctrl_clear);
      odd_q      <= odd_evt | (odd_q & ~ctrl_clear);
      unique case (state)
        IDLE: begin
          if (ctrl_enable) state <= WAIT_FS;
        end
        WAIT_FS: begin
          if (!ctrl_enable) begin
            state <= IDLE;
          end else if (fs) begin
            state       <= ACTIVE;
            sof_pending <= 1'b1;
            phase_odd   <= 1'b0;
            hold_valid  <= 1'b0;
          end
        end
        ACTIVE: begin
          if (overflow_evt) begin
            hold_valid <= 1'b0;
            phase_odd  <= 1'b0;
            state      <= fe ? WAIT_FS : DROP;
          end else begin
            if (byte_in) begin
              if (!phase_eff) begin
                hi_byte   <= data_s;
                phase_odd <= 1'b1;
              end else begin
                phase_odd   <= 1'b0;
                hold_pix    <= {hi_byte, data_s};
                hold_sof    <= sof_pending;
                sof_pending <= 1'b0;
                hold_valid  <= 1'b1;
              end
            end else if (href_rise) begin
              phase_odd <= 1'b0;
            end
            if (line_end) begin
              hold_valid <= 1'b0;
              phase_odd  <= 1'b0;
            end
            if (fe) begin
              frame_cnt <= frame_cnt + 1'b1;
              state     <= WAIT_FS;
            end
          end
        end
        DROP: begin
          if (fe) state <= WAIT_FS;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ov9655_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .wr_en   (push),
    .wr_data (push_entry),
    .rd_en   (m_axis_tready),
    .rd_data (pop_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid  = ~fifo_empty;
  assign m_axis_tdata   = pop_entry.pix;
  assign m_axis_tuser   = pop_entry.sof;
  assign m_axis_tlast   = pop_entry.eol;
  assign stat_frame_cnt = frame_cnt;
  assign stat_overflow  = overflow_q;
  assign stat_odd_line  = odd_q;
  assign stat_busy      = (state == ACTIVE) | (state == DROP);

endmodule
